// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked arbiter that shares one byte-wide UART transmit port
// between several requesters; new bytes launch only while the synchronized CTS is active.
module uart_tx_arbiter #(
    parameter int P_NUM_REQ   = 4,
    parameter int P_MAX_BURST = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [8*P_NUM_REQ-1:0] i_req_data,
    input  logic [P_NUM_REQ-1:0]   i_req_valid,
    input  logic [P_NUM_REQ-1:0]   i_req_last,
    output logic [P_NUM_REQ-1:0]   o_req_ready,
    output logic [7:0]             o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    input  logic                   i_uart_cts,
    output logic [P_NUM_REQ-1:0]   o_grant,
    output logic                   o_busy
);
    localparam int W = $clog2(P_NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t       state;
    state_t       next_state;
    logic [W-1:0] pointer;
    logic [W-1:0] sel;
    logic         sel_found;
    logic [1:0]   cts_sync;
    logic         cts_ok;
    logic [7:0]   burst_cnt;
    logic         buf_valid;
    logic [7:0]   buf_data;
    logic         can_load;
    logic         grant_valid;
    logic         grant_last;
    logic [7:0]   grant_data;
    logic         accept;
    logic         cap_hit;
    logic         release_grant;

    assign cts_ok        = ~cts_sync[1];
    assign can_load      = ~buf_valid | i_tx_ready;
    assign accept        = (state == GRANT) && cts_ok && can_load && grant_valid;
    assign cap_hit       = (P_MAX_BURST != 0) && (({1'b0, burst_cnt} + 9'd1) == 9'(P_MAX_BURST));
    assign release_grant = accept && (grant_last || cap_hit);

    always_comb begin
        grant_valid = 1'b0;
        grant_last  = 1'b0;
        grant_data  = '0;
        for (int k = 0; k < P_NUM_REQ; k++) begin
            if (pointer == W'(k)) begin
                grant_valid = i_req_valid[k];
                grant_last  = i_req_last[k];
                grant_data  = i_req_data[8*k +: 8];
            end
        end
    end

    // Lowest index above the pointer wins; otherwise wrap to the lowest index at or below it.
    always_comb begin
        sel       = pointer;
        sel_found = 1'b0;
        for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[k] && (k <= int'(pointer))) begin
                sel       = W'(k);
                sel_found = 1'b1;
            end
        end
        for (int k = P_NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[k] && (k > int'(pointer))) begin
                sel       = W'(k);
                sel_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (sel_found && cts_ok) next_state = GRANT;
            GRANT:   if (release_grant) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        o_grant     = '0;
        o_req_ready = '0;
        if (state == GRANT) begin
            for (int k = 0; k < P_NUM_REQ; k++) begin
                if (pointer == W'(k)) begin
                    o_grant[k]     = 1'b1;
                    o_req_ready[k] = cts_ok && can_load;
                end
            end
        end
        o_busy     = (state != IDLE) || buf_valid;
        o_tx_valid = buf_valid;
        o_tx_data  = buf_data;
    end

    // The single output buffer refills in the same cycle it drains, giving one byte per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            cts_sync  <= 2'b11;
            pointer   <= W'(P_NUM_REQ - 1);
            burst_cnt <= '0;
            buf_valid <= 1'b0;
            buf_data  <= '0;
        end else begin
            cts_sync <= {cts_sync[0], i_uart_cts};
            if (state == IDLE && next_state == GRANT) begin
                pointer   <= sel;
                burst_cnt <= '0;
            end else if (accept) begin
                burst_cnt <= burst_cnt + 8'd1;
            end
            if (accept) begin
                buf_valid <= 1'b1;
                buf_data  <= grant_data;
            end else if (i_tx_ready) begin
                buf_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a directed vector table, directed sequences and random traffic,
// all checked against a queue-based model of arbitration, flow control and the output buffer.
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int CAP = 4;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [8*N-1:0] i_req_data = '0;
    logic [N-1:0]   i_req_valid = '0;
    logic [N-1:0]   i_req_last = '0;
    logic [N-1:0]   o_req_ready;
    logic [7:0]     o_tx_data;
    logic           o_tx_valid;
    logic           i_tx_ready = 1'b1;
    logic           i_uart_cts = 1'b1;
    logic [N-1:0]   o_grant;
    logic           o_busy;

    uart_tx_arbiter #(.P_NUM_REQ(N), .P_MAX_BURST(CAP)) dut (
        .clock(clock), .reset(reset),
        .i_req_data(i_req_data), .i_req_valid(i_req_valid), .i_req_last(i_req_last),
        .o_req_ready(o_req_ready), .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid),
        .i_tx_ready(i_tx_ready), .i_uart_cts(i_uart_cts), .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic           rst;
        logic [N-1:0]   valid;
        logic [N-1:0]   last;
        logic [8*N-1:0] data;
        logic           txr;
        logic           cts;
        logic [N-1:0]   eg;
        logic [N-1:0]   er;
        logic           etv;
        logic [7:0]     etd;
        logic           ebusy;
        logic           chk;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: per-requester byte queues, current owner, bytes owed to the driver.
    logic [8:0] src_q [N][$];
    logic [7:0] exp_q[$];
    logic [7:0] out_log[$];
    logic [7:0] exp_log[$];
    int         owner = -1;
    int         last_owner = N - 1;
    int         burst = 0;
    int         acc_total = 0;
    int         total_pushed = 0;
    logic       cts_d1 = 1'b1;
    logic       cts_d2 = 1'b1;

    task automatic compare_field(input string name, input string field, input logic [31:0] got,
                                 input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s %s: got %h, expected %h", name, field, got, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s: cycle budget expired, got timeout, expected completion", name);
    endtask

    task automatic applyStimulus(input logic rst, input logic [N-1:0] v, input logic [N-1:0] l,
                                 input logic [8*N-1:0] d, input logic txr, input logic cts);
        @(negedge clock);
        reset       = rst;
        i_req_valid = v;
        i_req_last  = l;
        i_req_data  = d;
        i_tx_ready  = txr;
        i_uart_cts  = cts;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [N-1:0] eg, input logic [N-1:0] er,
                               input logic etv, input logic [7:0] etd, input logic ebusy);
        compare_field(name, "o_grant", 32'(o_grant), 32'(eg));
        compare_field(name, "o_req_ready", 32'(o_req_ready), 32'(er));
        compare_field(name, "o_tx_valid", 32'(o_tx_valid), 32'(etv));
        if (etv) compare_field(name, "o_tx_data", 32'(o_tx_data), 32'(etd));
        compare_field(name, "o_busy", 32'(o_busy), 32'(ebusy));
    endtask

    task automatic model_cycle(input string name, input logic rst, input logic txr, input logic cts,
                               input logic [N-1:0] gate);
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [8*N-1:0] d;
        logic [N-1:0]   eg;
        logic [N-1:0]   er;
        logic [8:0]     e;
        logic           cts_ok;
        logic           can_load;
        v = '0;
        l = '0;
        d = '0;
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() > 0 && gate[k]) begin
                e = src_q[k][0];
                v[k] = 1'b1;
                l[k] = e[8];
                d[8*k +: 8] = e[7:0];
            end
        end
        applyStimulus(rst, v, l, d, txr, cts);
        cts_ok   = !cts_d2;
        can_load = (exp_q.size() == 0) || txr;
        eg = (owner >= 0) ? (N'(1) << owner) : '0;
        er = (owner >= 0 && can_load && cts_ok) ? eg : '0;
        if (!rst) begin
            checkOutput(name, eg, er, exp_q.size() > 0, (exp_q.size() > 0) ? exp_q[0] : 8'h00,
                        (owner >= 0) || (exp_q.size() > 0));
            if (o_tx_valid === 1'b1 && txr) out_log.push_back(o_tx_data);
        end
        if (rst) begin
            owner = -1;
            last_owner = N - 1;
            burst = 0;
            exp_q.delete();
            cts_d1 = 1'b1;
            cts_d2 = 1'b1;
        end else begin
            if (exp_q.size() > 0 && txr) void'(exp_q.pop_front());
            if (owner < 0) begin
                if (v != '0 && cts_ok) begin
                    for (int off = 1; off <= N; off++) begin
                        int c;
                        c = (last_owner + off) % N;
                        if (v[c]) begin
                            owner = c;
                            break;
                        end
                    end
                    last_owner = owner;
                    burst = 0;
                end
            end else if (v[owner] && er[owner]) begin
                e = src_q[owner].pop_front();
                exp_q.push_back(e[7:0]);
                burst++;
                acc_total++;
                if (e[8] || burst == CAP) owner = -1;
            end
            cts_d2 = cts_d1;
            cts_d1 = cts;
        end
    endtask

    function automatic logic pending();
        logic p;
        p = (exp_q.size() > 0) || (owner >= 0);
        for (int k = 0; k < N; k++) if (src_q[k].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic reset_model();
        model_cycle("reset", 1'b1, 1'b1, 1'b0, '1);
        model_cycle("reset", 1'b1, 1'b1, 1'b0, '1);
        out_log.delete();
        exp_log.delete();
        acc_total = 0;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            model_cycle(name, 1'b0, 1'b1, 1'b0, '1);
            n++;
        end
        if (pending()) fail_bound(name);
        model_cycle(name, 1'b0, 1'b1, 1'b0, '1);
    endtask

    task automatic check_log(input string name);
        compare_field(name, "byte count", 32'(out_log.size()), 32'(exp_log.size()));
        for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
            compare_field(name, $sformatf("byte %0d", i), 32'(out_log[i]), 32'(exp_log[i]));
    endtask

    task automatic push_packet(input int req, input logic [7:0] first, input int len);
        for (int i = 0; i < len; i++) begin
            src_q[req].push_back({(i == len - 1), first + 8'(i)});
            exp_log.push_back(first + 8'(i));
        end
    endtask

    vec_t vt[9];

    initial begin
        int n;
        int len;
        logic [7:0] b;
        logic cts_r;
        logic [N-1:0] gate;

        // Single requester 1 sends A5 then 5A(last), from reset.
        vt[0] = '{1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1] = '{1'b1, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[2] = '{1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[3] = '{1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[4] = '{1'b0, 4'h2, 4'h0, 32'h0000A500, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1};
        vt[5] = '{1'b0, 4'h2, 4'h0, 32'h0000A500, 1'b1, 1'b0, 4'h2, 4'h2, 1'b0, 8'h00, 1'b1, 1'b1};
        vt[6] = '{1'b0, 4'h2, 4'h2, 32'h00005A00, 1'b1, 1'b0, 4'h2, 4'h2, 1'b1, 8'hA5, 1'b1, 1'b1};
        vt[7] = '{1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b1, 8'h5A, 1'b1, 1'b1};
        vt[8] = '{1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 1'b0, 4'h0, 4'h0, 1'b0, 8'h00, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vt[i].rst, vt[i].valid, vt[i].last, vt[i].data, vt[i].txr, vt[i].cts);
            if (vt[i].chk)
                checkOutput($sformatf("vec%0d", i), vt[i].eg, vt[i].er, vt[i].etv, vt[i].etd, vt[i].ebusy);
        end

        $display("[TB] round robin");
        reset_model();
        for (int k = 0; k < N; k++) push_packet(k, 8'h10 + 8'(k), 1);
        push_packet(0, 8'h20, 1);
        drain("rr", 200);
        check_log("rr order");

        $display("[TB] burst cap");
        reset_model();
        for (int i = 0; i < 4; i++) exp_log.push_back(8'(i));
        exp_log.push_back(8'hC0);
        exp_log.push_back(8'hC1);
        for (int i = 4; i < 10; i++) exp_log.push_back(8'(i));
        for (int i = 0; i < 10; i++) src_q[0].push_back({(i == 9), 8'(i)});
        src_q[2].push_back({1'b0, 8'hC0});
        src_q[2].push_back({1'b1, 8'hC1});
        drain("burst", 300);
        check_log("burst order");

        $display("[TB] cts pause");
        reset_model();
        push_packet(1, 8'h30, 6);
        n = 0;
        while (acc_total < 1 && n < 50) begin
            model_cycle("cts", 1'b0, 1'b1, 1'b0, '1);
            n++;
        end
        if (acc_total < 1) fail_bound("cts start");
        for (int i = 0; i < 6; i++) model_cycle("cts hold", 1'b0, 1'b1, 1'b1, '1);
        drain("cts", 200);
        check_log("cts order");

        $display("[TB] backpressure");
        reset_model();
        push_packet(3, 8'h40, 3);
        n = 0;
        while (exp_q.size() == 0 && n < 50) begin
            model_cycle("bp", 1'b0, 1'b1, 1'b0, '1);
            n++;
        end
        if (exp_q.size() == 0) fail_bound("bp start");
        for (int i = 0; i < 5; i++) model_cycle("bp stall", 1'b0, 1'b0, 1'b0, '1);
        drain("bp", 200);
        check_log("bp order");

        $display("[TB] reset mid-packet");
        reset_model();
        for (int i = 0; i < 4; i++) src_q[2].push_back({(i == 3), 8'h50 + 8'(i)});
        n = 0;
        while (!(exp_q.size() > 0 && owner == 2) && n < 50) begin
            model_cycle("mid", 1'b0, 1'b0, 1'b0, '1);
            n++;
        end
        if (!(exp_q.size() > 0 && owner == 2)) fail_bound("mid start");
        src_q[0].push_back({1'b1, 8'h60});
        model_cycle("mid reset", 1'b1, 1'b0, 1'b0, '1);
        out_log.delete();
        exp_log.delete();
        exp_log.push_back(8'h60);
        exp_log.push_back(8'h51);
        exp_log.push_back(8'h52);
        exp_log.push_back(8'h53);
        model_cycle("after reset", 1'b0, 1'b1, 1'b0, '1);
        compare_field("after reset", "o_tx_valid", 32'(o_tx_valid), 32'd0);
        compare_field("after reset", "o_grant", 32'(o_grant), 32'd0);
        compare_field("after reset", "o_busy", 32'(o_busy), 32'd0);
        drain("mid", 200);
        check_log("mid order");

        $display("[TB] random traffic");
        reset_model();
        total_pushed = 0;
        cts_r = 1'b0;
        for (int c = 0; c < 2500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (src_q[k].size() == 0 && $urandom_range(0, 9) == 0) begin
                    len = $urandom_range(1, 6);
                    for (int i = 0; i < len; i++) begin
                        b = 8'($urandom);
                        src_q[k].push_back({(i == len - 1), b});
                    end
                    total_pushed += len;
                end
            end
            for (int k = 0; k < N; k++) gate[k] = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) cts_r = ~cts_r;
            model_cycle("rand", 1'b0, ($urandom_range(0, 3) != 0), cts_r, gate);
        end
        drain("rand", 2000);
        compare_field("rand", "delivered count", 32'(out_log.size()), 32'(total_pushed));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
